// File: rtl/smaqa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : smaqa_pkg
//  Description : Shared types and constants for the SMAQA issue stage:
//                functional-unit opcodes, the queued entry layout and the
//                regfile read-port index mapping.
//  Revision    : 1.0 - initial release
// ============================================================================
package smaqa_pkg;

    // Transaction id width carried through the issue stage
    localparam int unsigned c_trans_id_bits = 3;

    // Regfile read-port / operand index mapping
    localparam int unsigned c_opnd_rs1 = 0;
    localparam int unsigned c_opnd_rs2 = 1;
    localparam int unsigned c_opnd_rd  = 2;

    // Functional-unit operation; ADD is the idle/reset encoding
    typedef enum logic [3:0] {
        ADD    = 4'd0,
        MUL    = 4'd1,
        MULH   = 4'd2,
        MULHU  = 4'd3,
        MULHSU = 4'd4,
        SMAQA  = 4'd5
    } fu_op;

    // One decoded entry waiting in the issue FIFO
    typedef struct packed {
        fu_op                       op;
        logic [4:0]                 rs1;
        logic [4:0]                 rs2;
        logic [4:0]                 rd;
        logic [c_trans_id_bits-1:0] trans_id;
    } smaqa_entry_t;

endpackage
`default_nettype wire

// File: rtl/fifo_v3.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_v3
//  Description : Small synchronous FIFO with optional fall-through, status
//                counter based full/empty and synchronous flush.
//                DEPTH must be a power of two so the pointers wrap naturally.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DEPTH        = 2,
    parameter type         dtype        = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    output logic full_o,
    output logic empty_o,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i
);

    localparam int unsigned c_addr_depth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_addr_depth-1:0] c_ptr_one = 1;
    localparam logic [c_addr_depth:0]   c_cnt_one = 1;
    localparam logic [c_addr_depth:0]   c_cnt_full = (c_addr_depth+1)'(DEPTH);

    logic [c_addr_depth-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_addr_depth-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_addr_depth:0]   cnt_q, cnt_d;
    logic                    w_we;
    dtype                    mem_q [DEPTH];

    assign full_o  = (cnt_q == c_cnt_full);
    assign empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);

    // Pointer/count next state and read data (bypass only when fall-through)
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        w_we     = 1'b0;
        data_o   = mem_q[rd_ptr_q];

        if (push_i && !full_o) begin
            w_we     = 1'b1;
            wr_ptr_d = wr_ptr_q + c_ptr_one;
            cnt_d    = cnt_q + c_cnt_one;
        end

        if (pop_i && !empty_o) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
            cnt_d    = (push_i && !full_o) ? cnt_q : (cnt_q - c_cnt_one);
        end

        if (FALL_THROUGH && (cnt_q == '0) && push_i) begin
            data_o = data_i;
            if (pop_i) begin
                cnt_d    = cnt_q;
                rd_ptr_d = rd_ptr_q;
                wr_ptr_d = wr_ptr_q;
                w_we     = 1'b0;
            end
        end

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
            w_we     = 1'b0;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents are only meaningful behind the count
    always_ff @(posedge clk_i) begin
        if (w_we) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/smaqa_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : smaqa_issue_stage
//  Description : In-order issue stage in front of the multiplier. Queues
//                decoded entries, reads rs1/rs2/rd, stalls on RAW/WAW hazards
//                against a busy scoreboard, forwards from the writeback bus
//                and drives a registered valid/ready operand interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module smaqa_issue_stage
    import smaqa_pkg::*;
#(
    parameter int unsigned DEPTH         = 2,
    parameter int unsigned TRANS_ID_BITS = c_trans_id_bits
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          instr_valid_i,
    output logic                          instr_ready_o,
    input  fu_op                          instr_op_i,
    input  logic [4:0]                    instr_rs1_i,
    input  logic [4:0]                    instr_rs2_i,
    input  logic [4:0]                    instr_rd_i,
    input  logic [TRANS_ID_BITS-1:0]      instr_trans_id_i,
    output logic [2:0][4:0]               raddr_o,
    input  logic [2:0][31:0]              rdata_i,
    input  logic                          wb_valid_i,
    input  logic [4:0]                    wb_rd_i,
    input  logic [31:0]                   wb_data_i,
    output logic                          mult_valid_o,
    input  logic                          mult_ready_i,
    output fu_op                          operation_o,
    output logic [31:0]                   operand_a_o,
    output logic [31:0]                   operand_b_o,
    output logic [31:0]                   operand_c_o,
    output logic [TRANS_ID_BITS-1:0]      trans_id_o
);

    smaqa_entry_t            w_push_entry;
    smaqa_entry_t            w_head;
    logic                    w_push;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_head_valid;
    logic                    w_is_smaqa;
    logic                    w_hazard;
    logic                    w_issue;
    logic [2:0][4:0]         w_idx;
    logic [2:0]              w_wb_hit;
    logic [2:0]              w_reg_hz;
    logic [2:0][31:0]        w_opnd;

    logic [31:0]             busy_q, busy_d;
    logic                    mult_valid_q, mult_valid_d;
    fu_op                    op_q, op_d;
    logic [31:0]             opa_q, opa_d;
    logic [31:0]             opb_q, opb_d;
    logic [31:0]             opc_q, opc_d;
    logic [TRANS_ID_BITS-1:0] tid_q, tid_d;

    // ------------------------------------------------------------------
    // Entry FIFO; ready is the registered "not full" so a pop in the same
    // cycle never re-opens the input early.
    // ------------------------------------------------------------------
    assign w_push_entry = '{op:       instr_op_i,
                            rs1:      instr_rs1_i,
                            rs2:      instr_rs2_i,
                            rd:       instr_rd_i,
                            trans_id: instr_trans_id_i};
    assign instr_ready_o = !w_fifo_full;
    assign w_push        = instr_valid_i && instr_ready_o;
    assign w_head_valid  = !w_fifo_empty;

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DEPTH        (DEPTH),
        .dtype        (smaqa_entry_t)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .data_i  (w_push_entry),
        .push_i  (w_push),
        .data_o  (w_head),
        .pop_i   (w_issue)
    );

    // ------------------------------------------------------------------
    // Read ports, hazard detection and forwarding per operand port
    // ------------------------------------------------------------------
    assign w_idx[c_opnd_rs1] = w_head.rs1;
    assign w_idx[c_opnd_rs2] = w_head.rs2;
    assign w_idx[c_opnd_rd]  = w_head.rd;
    assign raddr_o           = w_head_valid ? w_idx : '0;

    for (genvar k = 0; k < 3; k++) begin : g_port
        assign w_wb_hit[k] = wb_valid_i && (wb_rd_i == w_idx[k]);
        // A writeback landing this cycle resolves the hazard via forwarding
        assign w_reg_hz[k] = busy_q[w_idx[k]] && !w_wb_hit[k];
        assign w_opnd[k]   = (w_idx[k] == 5'd0) ? 32'd0 :
                             (w_wb_hit[k]       ? wb_data_i : rdata_i[k]);
    end

    // rd is always a WAW check; for SMAQA it is additionally the c source
    assign w_is_smaqa = (w_head.op == SMAQA);
    assign w_hazard   = |w_reg_hz;
    assign w_issue    = w_head_valid && !w_hazard && (!mult_valid_q || mult_ready_i);

    // Busy scoreboard next state: clear on writeback, set on issue (set wins)
    always_comb begin
        busy_d = busy_q;
        if (wb_valid_i) begin
            busy_d[wb_rd_i] = 1'b0;
        end
        if (w_issue && (w_head.rd != 5'd0)) begin
            busy_d[w_head.rd] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    // Output register next state: load on issue, hold under backpressure
    always_comb begin
        mult_valid_d = mult_valid_q;
        op_d         = op_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        opc_d        = opc_q;
        tid_d        = tid_q;
        if (flush_i) begin
            mult_valid_d = 1'b0;
        end else if (w_issue) begin
            mult_valid_d = 1'b1;
            op_d         = w_head.op;
            opa_d        = w_opnd[c_opnd_rs1];
            opb_d        = w_opnd[c_opnd_rs2];
            opc_d        = w_is_smaqa ? w_opnd[c_opnd_rd] : 32'd0;
            tid_d        = w_head.trans_id;
        end else if (mult_ready_i) begin
            mult_valid_d = 1'b0;
        end
    end

    // State registers for the scoreboard and the multiplier-facing outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q       <= '0;
            mult_valid_q <= 1'b0;
            op_q         <= ADD;
            opa_q        <= '0;
            opb_q        <= '0;
            opc_q        <= '0;
            tid_q        <= '0;
        end else begin
            busy_q       <= busy_d;
            mult_valid_q <= mult_valid_d;
            op_q         <= op_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            opc_q        <= opc_d;
            tid_q        <= tid_d;
        end
    end

    assign mult_valid_o = mult_valid_q;
    assign operation_o  = op_q;
    assign operand_a_o  = opa_q;
    assign operand_b_o  = opb_q;
    assign operand_c_o  = opc_q;
    assign trans_id_o   = tid_q;

endmodule
`default_nettype wire

// File: tb/tb_smaqa_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_smaqa_issue_stage
//  Description : Self-checking bench for smaqa_issue_stage: directed scenarios
//                with literal expectations, then randomized traffic checked
//                every cycle against a queue-based behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_smaqa_issue_stage;
    import smaqa_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned TIDW  = c_trans_id_bits;

    logic             clk;
    logic             rst_ni;
    logic             flush_i;
    logic             instr_valid_i;
    logic             instr_ready_o;
    fu_op             instr_op_i;
    logic [4:0]       instr_rs1_i, instr_rs2_i, instr_rd_i;
    logic [TIDW-1:0]  instr_trans_id_i;
    logic [2:0][4:0]  raddr_o;
    logic [2:0][31:0] rdata_i;
    logic             wb_valid_i;
    logic [4:0]       wb_rd_i;
    logic [31:0]      wb_data_i;
    logic             mult_valid_o;
    logic             mult_ready_i;
    fu_op             operation_o;
    logic [31:0]      operand_a_o, operand_b_o, operand_c_o;
    logic [TIDW-1:0]  trans_id_o;

    logic [31:0]      regs [32];
    logic             ones;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    smaqa_entry_t     mq[$];
    bit [31:0]        mbusy;
    bit               mv;
    fu_op             mop;
    logic [31:0]      ma, mb, mc;
    logic [TIDW-1:0]  mid;
    logic [TIDW-1:0]  hs_log[$];

    smaqa_issue_stage #(.DEPTH(DEPTH), .TRANS_ID_BITS(TIDW)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .instr_valid_i    (instr_valid_i),
        .instr_ready_o    (instr_ready_o),
        .instr_op_i       (instr_op_i),
        .instr_rs1_i      (instr_rs1_i),
        .instr_rs2_i      (instr_rs2_i),
        .instr_rd_i       (instr_rd_i),
        .instr_trans_id_i (instr_trans_id_i),
        .raddr_o          (raddr_o),
        .rdata_i          (rdata_i),
        .wb_valid_i       (wb_valid_i),
        .wb_rd_i          (wb_rd_i),
        .wb_data_i        (wb_data_i),
        .mult_valid_o     (mult_valid_o),
        .mult_ready_i     (mult_ready_i),
        .operation_o      (operation_o),
        .operand_a_o      (operand_a_o),
        .operand_b_o      (operand_b_o),
        .operand_c_o      (operand_c_o),
        .trans_id_o       (trans_id_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile: combinational read of whatever the DUT addresses
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            rdata_i[k] = ones ? 32'hFFFF_FFFF : regs[raddr_o[k]];
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural value a read of register r yields this cycle
    function automatic logic [31:0] reg_value(logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_valid_i && wb_rd_i == r) return wb_data_i;
        return ones ? 32'hFFFF_FFFF : regs[r];
    endfunction

    function automatic bit blocked(logic [4:0] r);
        return (r != 5'd0) && mbusy[r] && !(wb_valid_i && wb_rd_i == r);
    endfunction

    task automatic model_reset();
        mq.delete();
        mbusy = '0;
        mv    = 1'b0;
        mop   = ADD;
        ma    = '0;
        mb    = '0;
        mc    = '0;
        mid   = '0;
    endtask

    // One clock edge of the specified behaviour
    task automatic model_step();
        bit           issue;
        bit           push;
        smaqa_entry_t e;
        if (!rst_ni) begin
            model_reset();
            return;
        end
        issue = 1'b0;
        push  = instr_valid_i && (mq.size() < DEPTH);
        if (mq.size() != 0) begin
            e     = mq[0];
            issue = !blocked(e.rs1) && !blocked(e.rs2) && !blocked(e.rd) && (!mv || mult_ready_i);
        end
        if (flush_i) begin
            mq.delete();
            mv    = 1'b0;
            mbusy = '0;
            return;
        end
        if (wb_valid_i) mbusy[wb_rd_i] = 1'b0;
        if (issue) begin
            void'(mq.pop_front());
            mv  = 1'b1;
            mop = e.op;
            ma  = reg_value(e.rs1);
            mb  = reg_value(e.rs2);
            mc  = (e.op == SMAQA) ? reg_value(e.rd) : 32'd0;
            mid = e.trans_id;
            if (e.rd != 5'd0) mbusy[e.rd] = 1'b1;
        end else if (mult_ready_i) begin
            mv = 1'b0;
        end
        if (push) begin
            mq.push_back('{op: instr_op_i, rs1: instr_rs1_i, rs2: instr_rs2_i,
                           rd: instr_rd_i, trans_id: instr_trans_id_i});
        end
        mbusy[0] = 1'b0;
    endtask

    task automatic compare();
        logic [2:0][4:0] er;
        er = '0;
        if (mq.size() != 0) begin
            er[0] = mq[0].rs1;
            er[1] = mq[0].rs2;
            er[2] = mq[0].rd;
        end
        chk("mult_valid", 32'(mult_valid_o), 32'(mv));
        chk("operation", 32'(operation_o), 32'(mop));
        chk("operand_a", operand_a_o, ma);
        chk("operand_b", operand_b_o, mb);
        chk("operand_c", operand_c_o, mc);
        chk("trans_id", 32'(trans_id_o), 32'(mid));
        chk("instr_ready", 32'(instr_ready_o), 32'(mq.size() < DEPTH));
        chk("raddr", 32'(raddr_o), 32'(er));
    endtask

    task automatic cycle();
        if (mult_valid_o && mult_ready_i) hs_log.push_back(trans_id_o);
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic set_instr(logic v, fu_op op, logic [4:0] r1, logic [4:0] r2,
                             logic [4:0] rdx, logic [TIDW-1:0] id);
        instr_valid_i    = v;
        instr_op_i       = op;
        instr_rs1_i      = r1;
        instr_rs2_i      = r2;
        instr_rd_i       = rdx;
        instr_trans_id_i = id;
    endtask

    // Present an entry until the DUT accepts it, bounded
    task automatic push_hold(fu_op op, logic [4:0] r1, logic [4:0] r2,
                             logic [4:0] rdx, logic [TIDW-1:0] id);
        bit acc;
        int n;
        n = 0;
        set_instr(1'b1, op, r1, r2, rdx, id);
        do begin
            acc = instr_ready_o;
            cycle();
            n++;
        end while (!acc && n < 20);
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL push_timeout: actual=not_accepted required=accepted id=%0d", id);
        end
        instr_valid_i = 1'b0;
    endtask

    task automatic chk_reset_values(string tag);
        chk({tag, "_valid"}, 32'(mult_valid_o), 32'd0);
        chk({tag, "_ready"}, 32'(instr_ready_o), 32'd1);
        chk({tag, "_raddr"}, 32'(raddr_o), 32'd0);
        chk({tag, "_op"}, 32'(operation_o), 32'(ADD));
        chk({tag, "_a"}, operand_a_o, 32'd0);
        chk({tag, "_b"}, operand_b_o, 32'd0);
        chk({tag, "_c"}, operand_c_o, 32'd0);
        chk({tag, "_id"}, 32'(trans_id_o), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst_ni        = 1'b0;
        flush_i       = 1'b0;
        ones          = 1'b0;
        wb_valid_i    = 1'b0;
        wb_rd_i       = '0;
        wb_data_i     = '0;
        mult_ready_i  = 1'b1;
        set_instr(1'b0, ADD, 5'd0, 5'd0, 5'd0, '0);
        for (int r = 0; r < 32; r++) regs[r] = 32'h1000_0000 + r;
        regs[1] = 32'h0102_0304;
        regs[2] = 32'h0506_0708;
        regs[3] = 32'h0000_0009;
        regs[6] = 32'h0000_0066;
        model_reset();

        #12;
        chk_reset_values("reset");
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // Basic SMAQA: push at N, valid at N+2
        set_instr(1'b1, SMAQA, 5'd1, 5'd2, 5'd3, 3'd5);
        cycle();
        chk("t1_valid_n1", 32'(mult_valid_o), 32'd0);
        set_instr(1'b1, SMAQA, 5'd3, 5'd2, 5'd6, 3'd6);
        cycle();
        chk("t1_valid_n2", 32'(mult_valid_o), 32'd1);
        chk("t1_a", operand_a_o, 32'h0102_0304);
        chk("t1_b", operand_b_o, 32'h0506_0708);
        chk("t1_c", operand_c_o, 32'h0000_0009);
        chk("t1_id", 32'(trans_id_o), 32'd5);

        // RAW stall on rs1=3 until writeback, then forward
        instr_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t2_stall", 32'(mult_valid_o), 32'd0);
        end
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd3;
        wb_data_i  = 32'h0000_004F;
        cycle();
        wb_valid_i = 1'b0;
        chk("t2_valid", 32'(mult_valid_o), 32'd1);
        chk("t2_a", operand_a_o, 32'h0000_004F);
        chk("t2_c", operand_c_o, 32'h0000_0066);
        chk("t2_id", 32'(trans_id_o), 32'd6);

        // Backpressure: 4 cycles of not-ready while three entries arrive
        hs_log.delete();
        mult_ready_i = 1'b0;
        push_hold(SMAQA, 5'd1, 5'd2, 5'd7, 3'd1);
        push_hold(MUL, 5'd1, 5'd2, 5'd8, 3'd2);
        chk("t3_full", 32'(instr_ready_o), 32'd0);
        set_instr(1'b1, SMAQA, 5'd1, 5'd2, 5'd9, 3'd3);
        cycle();
        cycle();
        chk("t3_full_hold", 32'(instr_ready_o), 32'd0);
        chk("t3_hold_id", 32'(trans_id_o), 32'd6);
        chk("t3_hold_a", operand_a_o, 32'h0000_004F);
        mult_ready_i = 1'b1;
        push_hold(SMAQA, 5'd1, 5'd2, 5'd9, 3'd3);
        for (int i = 0; i < 5; i++) cycle();
        chk("t3_order_n", 32'(hs_log.size()), 32'd4);
        if (hs_log.size() == 4) begin
            chk("t3_order0", 32'(hs_log[0]), 32'd6);
            chk("t3_order1", 32'(hs_log[1]), 32'd1);
            chk("t3_order2", 32'(hs_log[2]), 32'd2);
            chk("t3_order3", 32'(hs_log[3]), 32'd3);
        end

        // x0 handling with all-ones read data
        ones = 1'b1;
        set_instr(1'b1, SMAQA, 5'd0, 5'd2, 5'd0, 3'd4);
        cycle();
        set_instr(1'b1, MUL, 5'd0, 5'd0, 5'd0, 3'd5);
        cycle();
        chk("t4_valid", 32'(mult_valid_o), 32'd1);
        chk("t4_a", operand_a_o, 32'd0);
        chk("t4_b", operand_b_o, 32'hFFFF_FFFF);
        chk("t4_c", operand_c_o, 32'd0);
        chk("t4_id", 32'(trans_id_o), 32'd4);
        instr_valid_i = 1'b0;
        cycle();
        chk("t4_next_valid", 32'(mult_valid_o), 32'd1);
        chk("t4_next_id", 32'(trans_id_o), 32'd5);
        ones = 1'b0;
        cycle();

        // Set/clear collision on r4: the issue's set must win
        set_instr(1'b1, SMAQA, 5'd1, 5'd2, 5'd4, 3'd7);
        cycle();
        set_instr(1'b1, MUL, 5'd4, 5'd0, 5'd10, 3'd0);
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd4;
        wb_data_i  = 32'h0000_0123;
        cycle();
        chk("t5_c_fwd", operand_c_o, 32'h0000_0123);
        wb_valid_i    = 1'b0;
        instr_valid_i = 1'b0;
        cycle();
        cycle();
        chk("t5_busy_stall", 32'(mult_valid_o), 32'd0);
        wb_valid_i = 1'b1;
        wb_data_i  = 32'h0000_0ABC;
        cycle();
        wb_valid_i = 1'b0;
        chk("t5_release", 32'(mult_valid_o), 32'd1);
        chk("t5_a", operand_a_o, 32'h0000_0ABC);

        // Flush with two queued entries, a pending output and busy[3]
        push_hold(MUL, 5'd1, 5'd2, 5'd3, 3'd1);
        cycle();
        mult_ready_i = 1'b0;
        push_hold(SMAQA, 5'd1, 5'd2, 5'd11, 3'd2);
        push_hold(MUL, 5'd1, 5'd2, 5'd12, 3'd3);
        chk("t6_pre_valid", 32'(mult_valid_o), 32'd1);
        flush_i = 1'b1;
        set_instr(1'b1, MUL, 5'd1, 5'd2, 5'd13, 3'd4);
        cycle();
        flush_i       = 1'b0;
        instr_valid_i = 1'b0;
        chk("t6_valid", 32'(mult_valid_o), 32'd0);
        chk("t6_ready", 32'(instr_ready_o), 32'd1);
        chk("t6_raddr", 32'(raddr_o), 32'd0);
        mult_ready_i = 1'b1;
        set_instr(1'b1, SMAQA, 5'd3, 5'd11, 5'd12, 3'd5);
        cycle();
        instr_valid_i = 1'b0;
        cycle();
        chk("t6_busy_cleared", 32'(mult_valid_o), 32'd1);
        chk("t6_id", 32'(trans_id_o), 32'd5);

        // Randomized traffic against the model
        for (int r = 1; r < 32; r++) regs[r] = $urandom;
        for (int i = 0; i < 3000; i++) begin
            fu_op rop;
            case ($urandom_range(0, 5))
                0: rop = ADD;
                1: rop = MUL;
                2: rop = MULH;
                3: rop = MULHU;
                4: rop = MULHSU;
                default: rop = SMAQA;
            endcase
            set_instr(($urandom_range(0, 99) < 60), rop, 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), TIDW'($urandom));
            wb_valid_i   = ($urandom_range(0, 99) < 35);
            wb_rd_i      = 5'($urandom_range(0, 7));
            wb_data_i    = $urandom;
            mult_ready_i = ($urandom_range(0, 99) < 65);
            flush_i      = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 9) == 0) regs[$urandom_range(1, 7)] = $urandom;
            cycle();
            if (i == 1500) begin
                #2;
                rst_ni = 1'b0;
                #1;
                chk_reset_values("async_reset");
                model_reset();
                cycle();
                rst_ni = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/smaqa_issue_stage.md
# smaqa_issue_stage

In-order issue stage that sits directly upstream of the `multiplier` for the SMAQA (signed 8-bit quad multiply-accumulate) path. It accepts decoded SMAQA/MUL-class entries from the decoder into a small FIFO, reads rs1/rs2/rd through three regfile read ports, and blocks on read-after-write and write-after-write hazards against in-flight results. Operands are forwarded from the writeback bus, and the block drives the multiplier with a registered valid/ready handshake carrying three operands (a, b, c = old rd value).

## Interface
- `DEPTH`, 2: instruction FIFO entries; power of two, at least 2.
- `TRANS_ID_BITS`, `ariane_pkg::TRANS_ID_BITS`: transaction id width.
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `flush_i`  in  1  synchronous flush: drops FIFO, output register and busy bits
- `instr_valid_i`  in  1  decoded entry valid
- `instr_ready_o`  out  1  FIFO not full
- `instr_op_i`  in  `fu_op`  operation (SMAQA, MUL, …)
- `instr_rs1_i`, `instr_rs2_i`, `instr_rd_i`  in  5 each  register indices
- `instr_trans_id_i`  in  `TRANS_ID_BITS`  id
- `raddr_o`  out  [2:0][4:0]  regfile read addresses: 0=rs1, 1=rs2, 2=rd
- `rdata_i`  in  [2:0][31:0]  regfile read data; combinational, same cycle
- `wb_valid_i`  in  1  writeback valid (any unit)
- `wb_rd_i`  in  5  writeback destination
- `wb_data_i`  in  32  writeback data
- `mult_valid_o`  out  1  operands valid to multiplier
- `mult_ready_i`  in  1  multiplier ready
- `operation_o`  out  `fu_op`
- `operand_a_o`, `operand_b_o`, `operand_c_o`  out  32 each
- `trans_id_o`  out  `TRANS_ID_BITS`

## Operation
- FIFO push when `instr_valid_i && instr_ready_o`. `instr_ready_o` = FIFO not full; it does not depend on `instr_valid_i`.
- `raddr_o` always presents the head entry's rs1, rs2 and rd. It is driven with 0 when the FIFO is empty.
- Busy scoreboard: 32 bits; bit 0 is hardwired to 0.
- Head hazard on a register r exists when busy[r] is set and there is no same-cycle writeback with `wb_valid_i && wb_rd_i == r`.
  - Registers checked: rs1, rs2, and rd.
  - For SMAQA, rd is both a source and a WAW check. For other ops, rd is a WAW check only.
- Operand selection per port, in priority order:
  1. Register index 0 → 0.
  2. Same-cycle writeback match → `wb_data_i`.
  3. Otherwise → `rdata_i`.
- `operand_c` for non-SMAQA ops is 0.
- Issue condition: head valid, no hazard, and output register free or draining (`!mult_valid_o || mult_ready_i`).
- On issue:
  - FIFO pops.
  - Output register loads op, operands and trans_id.
  - `mult_valid_o` is set.
  - busy[rd] is set when rd ≠ 0.
- Busy clear: `wb_valid_i` clears busy[`wb_rd_i`]. If the same cycle issues with rd = `wb_rd_i`, the set wins.
- The output register holds all fields stable while `mult_valid_o && !mult_ready_i`.
- `flush_i` has priority over everything, including a same-cycle push or issue:
  - empties the FIFO,
  - clears `mult_valid_o`,
  - clears all busy bits.

## Timing
- Reset values:
  - `mult_valid_o`=0; `operation_o`=ADD; all operands=0; `trans_id_o`=0.
  - `instr_ready_o`=1; `raddr_o`=0; all busy=0; FIFO empty.
- Latency with no hazard: push in cycle N → head in N+1 → `mult_valid_o` high in N+2.
- Throughput: one issue per cycle while `mult_ready_i` stays high.
- Full FIFO: `instr_ready_o`=0; a simultaneous pop does not raise ready in the same cycle.
- Reset asserted mid-operation: everything returns to reset values asynchronously; no partial issue survives.

## Structure
- Shared package `smaqa_pkg`:
  - `smaqa_entry_t` struct {op, rs1, rs2, rd, trans_id}.
  - Constant for the operand port index mapping.
- Sub-module: `fifo_v3` (common_cells) instantiated for the entry FIFO, with FALL_THROUGH=0.
- Scoreboard, forwarding mux and output register are inline.

## Test plan
1. **Basic SMAQA:**
   - Stimulus: regfile R1=0x01020304, R2=0x05060708, R3=0x00000009; push SMAQA rs1=1, rs2=2, rd=3, id=5.
   - Required: `mult_valid_o` at N+2 with a=0x01020304, b=0x05060708, c=0x9, `trans_id_o`=5, busy[3]=1.
2. **RAW stall and forward:**
   - Stimulus: push a second SMAQA with rs1=3 behind the first. Keep `wb_valid_i`=0 for 3 cycles, then drive wb rd=3, data=0x4F.
   - Required: no issue while stalled; issue in the wb cycle with a=0x4F.
3. **Backpressure:**
   - Stimulus: `mult_ready_i`=0 for 4 cycles while 3 entries are pushed.
   - Required: outputs stable; `instr_ready_o` drops after 2 entries; all three issue in order once ready returns.
4. **x0 handling:**
   - Stimulus: SMAQA with rs1=0, rd=0, `rdata_i`=0xFFFFFFFF on all ports.
   - Required: a=0, c=0; no busy bit set; a following instruction with rd=0 is not stalled.
5. **Set/clear collision:**
   - Stimulus: wb rd=4 in the same cycle an entry with rd=4 issues.
   - Required: busy[4]=1 afterwards.
6. **Flush:**
   - Stimulus: `flush_i` with 2 queued entries, `mult_valid_o`=1 and busy[3]=1.
   - Required: next cycle FIFO empty, `mult_valid_o`=0, busy all 0, `instr_ready_o`=1.
